// File: rtl/lut_mult_pkg.sv
// ----------------------------------------------------------------------------
// lut_mult_pkg
// Shared definitions for the LUT multiplier datapath and its consumers.
//   state_t       : accumulator FSM states (ACCUM, HOLD)
//   PRODUCT_WIDTH : width of one multiplier product
//   clog2         : ceiling log2, used to size beat counters
// ----------------------------------------------------------------------------
package lut_mult_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int PRODUCT_WIDTH = 64;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/lut_dot_accumulator_64b.sv
// ----------------------------------------------------------------------------
// lut_dot_accumulator_64b
// Accumulates a stream of unsigned 64-bit products into one dot-product result
// per vector and presents it on a valid/ready handshake.
//
// Ports
//   clk_acc      : clock, rising edge
//   resetn_acc   : asynchronous active-low reset
//   clear_acc    : synchronous flush of any partial or held vector
//   in_valid     : product_64b carries a beat
//   in_ready     : block accepts a beat this cycle
//   product_64b  : unsigned product from the multiplier
//   in_last      : final beat of the current vector
//   out_valid    : acc_result / acc_count / overflow are valid
//   out_ready    : consumer takes the result
//   acc_result   : dot-product sum (the running sum register itself)
//   acc_count    : number of beats summed into acc_result
//   overflow     : the sum wrapped past ACC_WIDTH bits for this vector
// ----------------------------------------------------------------------------
module lut_dot_accumulator_64b
    import lut_mult_pkg::*;
#(
    parameter int ACC_WIDTH = 72,
    parameter int MAX_LEN   = 16,
    localparam int CNT_W    = clog2(MAX_LEN) + 1
) (
    input  logic                     clk_acc,
    input  logic                     resetn_acc,
    input  logic                     clear_acc,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PRODUCT_WIDTH-1:0] product_64b,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_WIDTH-1:0]     acc_result,
    output logic [CNT_W-1:0]         acc_count,
    output logic                     overflow
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_LEN - 1);

    state_t               state;
    logic [ACC_WIDTH-1:0] sum;
    logic [CNT_W-1:0]     count;
    logic                 ovf_flag;

    logic                 beat;
    logic [ACC_WIDTH:0]   sum_next;

    // in_ready is a register so it stays low through reset and only rises on
    // the first edge after deassertion; it therefore gates acceptance directly.
    assign beat = in_valid & in_ready;

    // One extra bit captures the carry out of the accumulator.
    assign sum_next = {1'b0, sum}
                    + {{(ACC_WIDTH - PRODUCT_WIDTH + 1){1'b0}}, product_64b};

    always_ff @(posedge clk_acc or negedge resetn_acc) begin
        if (!resetn_acc) begin
            state     <= ACCUM;
            sum       <= '0;
            count     <= '0;
            ovf_flag  <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else if (clear_acc) begin
            state     <= ACCUM;
            sum       <= '0;
            count     <= '0;
            ovf_flag  <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    in_ready <= 1'b1;
                    if (beat) begin
                        sum      <= sum_next[ACC_WIDTH-1:0];
                        count    <= count + CNT_W'(1);
                        ovf_flag <= ovf_flag | sum_next[ACC_WIDTH];
                        // Beat number MAX_LEN ends the vector regardless of in_last.
                        if (in_last || (count == LAST_IDX)) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= ACCUM;
                        sum       <= '0;
                        count     <= '0;
                        ovf_flag  <= 1'b0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ACCUM;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // The sum, count and flag registers freeze in HOLD, so they are the result.
    assign acc_result = sum;
    assign acc_count  = count;
    assign overflow   = ovf_flag;

endmodule

// File: tb/tb_lut_dot_accumulator_64b.sv
// ----------------------------------------------------------------------------
// tb_lut_dot_accumulator_64b
// Directed bench for lut_dot_accumulator_64b. Two instances share stimulus:
// dut72 (ACC_WIDTH=72, no overflow possible) and dut64 (ACC_WIDTH=64).
// ----------------------------------------------------------------------------
module tb_lut_dot_accumulator_64b;

    logic        clk_acc;
    logic        resetn_acc;
    logic        clear_acc;
    logic        in_valid;
    logic [63:0] product_64b;
    logic        in_last;
    logic        out_ready;

    logic        in_ready_a;
    logic        out_valid_a;
    logic [71:0] acc_result_a;
    logic [4:0]  acc_count_a;
    logic        overflow_a;

    logic        in_ready_b;
    logic        out_valid_b;
    logic [63:0] acc_result_b;
    logic [4:0]  acc_count_b;
    logic        overflow_b;

    int errors = 0;
    int checks = 0;

    lut_dot_accumulator_64b #(.ACC_WIDTH(72), .MAX_LEN(16)) dut72 (
        .clk_acc     (clk_acc),
        .resetn_acc  (resetn_acc),
        .clear_acc   (clear_acc),
        .in_valid    (in_valid),
        .in_ready    (in_ready_a),
        .product_64b (product_64b),
        .in_last     (in_last),
        .out_valid   (out_valid_a),
        .out_ready   (out_ready),
        .acc_result  (acc_result_a),
        .acc_count   (acc_count_a),
        .overflow    (overflow_a)
    );

    lut_dot_accumulator_64b #(.ACC_WIDTH(64), .MAX_LEN(16)) dut64 (
        .clk_acc     (clk_acc),
        .resetn_acc  (resetn_acc),
        .clear_acc   (clear_acc),
        .in_valid    (in_valid),
        .in_ready    (in_ready_b),
        .product_64b (product_64b),
        .in_last     (in_last),
        .out_valid   (out_valid_b),
        .out_ready   (out_ready),
        .acc_result  (acc_result_b),
        .acc_count   (acc_count_b),
        .overflow    (overflow_b)
    );

    initial clk_acc = 1'b0;
    always #5 clk_acc = ~clk_acc;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_acc);
        #1;
    endtask

    task automatic send_beat(input logic [63:0] prod, input logic last);
        in_valid    = 1'b1;
        product_64b = prod;
        in_last     = last;
        step();
        in_valid    = 1'b0;
        in_last     = 1'b0;
        product_64b = '0;
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        resetn_acc  = 1'b0;
        clear_acc   = 1'b0;
        in_valid    = 1'b0;
        product_64b = '0;
        in_last     = 1'b0;
        out_ready   = 1'b1;

        // Reset state
        step();
        step();
        check("rst_in_ready",   72'(in_ready_a),   72'(0));
        check("rst_out_valid",  72'(out_valid_a),  72'(0));
        check("rst_acc_result", acc_result_a,      72'(0));
        check("rst_acc_count",  72'(acc_count_a),  72'(0));
        check("rst_overflow",   72'(overflow_a),   72'(0));
        resetn_acc = 1'b1;
        step();
        check("post_rst_in_ready", 72'(in_ready_a), 72'(1));

        // Vector {3,5,7}
        send_beat(64'd3, 1'b0);
        send_beat(64'd5, 1'b0);
        check("v1_no_valid_early", 72'(out_valid_a), 72'(0));
        send_beat(64'd7, 1'b1);
        check("v1_out_valid",  72'(out_valid_a), 72'(1));
        check("v1_result",     acc_result_a,     72'(15));
        check("v1_count",      72'(acc_count_a), 72'(3));
        check("v1_overflow",   72'(overflow_a),  72'(0));
        check("v1_in_ready",   72'(in_ready_a),  72'(0));
        step();
        check("v1_valid_one_cycle", 72'(out_valid_a), 72'(0));
        check("v1_in_ready_back",   72'(in_ready_a),  72'(1));

        // 16 beats of all-ones with no in_last: forced end
        for (int i = 0; i < 15; i++) send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        check("v2_not_done_at_15", 72'(out_valid_a), 72'(0));
        send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        check("v2_out_valid", 72'(out_valid_a), 72'(1));
        check("v2_result",    acc_result_a,     72'hF_FFFF_FFFF_FFFF_FFF0);
        check("v2_count",     72'(acc_count_a), 72'(16));
        check("v2_overflow",  72'(overflow_a),  72'(0));
        check("v2_result64",  72'(acc_result_b), 72'h0_FFFF_FFFF_FFFF_FFF0);
        check("v2_overflow64", 72'(overflow_b), 72'(1));
        step();

        // Backpressure: {10,20}, out_ready low 5 cycles, upstream holding a beat
        out_ready = 1'b0;
        send_beat(64'd10, 1'b0);
        send_beat(64'd20, 1'b1);
        in_valid    = 1'b1;
        product_64b = 64'd1;
        in_last     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("v3_hold_valid",    72'(out_valid_a), 72'(1));
            check("v3_hold_result",   acc_result_a,     72'(30));
            check("v3_hold_in_ready", 72'(in_ready_a),  72'(0));
            step();
        end
        out_ready = 1'b1;
        step();
        check("v3_released",       72'(out_valid_a), 72'(0));
        check("v3_in_ready_back",  72'(in_ready_a),  72'(1));
        check("v3_sum_cleared",    acc_result_a,     72'(0));
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("v4_valid",  72'(out_valid_a), 72'(1));
        check("v4_result", acc_result_a,     72'(1));
        check("v4_count",  72'(acc_count_a), 72'(1));
        step();

        // Overflow at 64 bits: all-ones + 2
        send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send_beat(64'd2, 1'b1);
        check("v5_result64",   72'(acc_result_b), 72'(1));
        check("v5_overflow64", 72'(overflow_b),   72'(1));
        check("v5_result72",   acc_result_a,      72'h1_0000_0000_0000_0001);
        check("v5_overflow72", 72'(overflow_a),   72'(0));
        step();
        send_beat(64'd4, 1'b1);
        check("v6_result64",   72'(acc_result_b), 72'(4));
        check("v6_overflow64", 72'(overflow_b),   72'(0));
        step();

        // clear_acc after two beats of 9; beat presented with the clear is dropped
        send_beat(64'd9, 1'b0);
        send_beat(64'd9, 1'b0);
        check("v7_partial", acc_result_a, 72'(18));
        clear_acc   = 1'b1;
        in_valid    = 1'b1;
        product_64b = 64'd100;
        in_last     = 1'b1;
        step();
        clear_acc = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        check("clr_result",    acc_result_a,     72'(0));
        check("clr_count",     72'(acc_count_a), 72'(0));
        check("clr_out_valid", 72'(out_valid_a), 72'(0));
        send_beat(64'd6, 1'b1);
        check("v7_result", acc_result_a,     72'(6));
        check("v7_count",  72'(acc_count_a), 72'(1));
        step();

        // Asynchronous reset while in HOLD
        out_ready = 1'b0;
        send_beat(64'd5, 1'b1);
        check("v8_hold", 72'(out_valid_a), 72'(1));
        #2;
        resetn_acc = 1'b0;
        #1;
        check("arst_out_valid", 72'(out_valid_a), 72'(0));
        check("arst_result",    acc_result_a,     72'(0));
        check("arst_count",     72'(acc_count_a), 72'(0));
        check("arst_in_ready",  72'(in_ready_a),  72'(0));
        resetn_acc = 1'b1;
        out_ready  = 1'b1;
        step();
        check("arst_in_ready_back", 72'(in_ready_a), 72'(1));
        send_beat(64'd8, 1'b1);
        check("v9_result", acc_result_a,     72'(8));
        check("v9_count",  72'(acc_count_a), 72'(1));
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
